// File: rtl/comma_align_deser.sv
// K28.5 comma aligner / deserializer: hunts for the comma in the recovered bit stream,
// locks symbol alignment and emits aligned 10-bit symbols. Optional macro COMMA_ALIGN_DESER_LOSS_CNT_EN adds a lock-loss event counter.
module comma_align_deser #(
    parameter logic [9:0]  COMMA_P    = 10'b0011111010,
    parameter logic [9:0]  COMMA_N    = 10'b1100000101,
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned LOSS_COUNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clkStrobe,
    input  logic       rxClocked,
    output logic [9:0] symbol,
    output logic       symbolValid,
    output logic       isComma,
    output logic       locked
`ifdef COMMA_ALIGN_DESER_LOSS_CNT_EN
    ,
    output logic [7:0] lossEvents
`endif
);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [3:0] LOCK_TH = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_TH = 4'(LOSS_COUNT);

    logic [1:0] state_r;
    logic [1:0] stateNxt_s;
    logic [8:0] shiftReg_r;      // bit 9 of the window is never needed again after a shift
    logic [3:0] bitCnt_r;
    logic [3:0] bitCntNxt_s;
    logic [3:0] commaCnt_r;
    logic [3:0] commaCntNxt_s;
    logic [3:0] lossCnt_r;
    logic [3:0] lossCntNxt_s;
    logic [9:0] symbol_r;
    logic [9:0] symbolNxt_s;
    logic       symbolValid_r;
    logic       symbolValidNxt_s;
    logic       isComma_r;
    logic       isCommaNxt_s;
    logic       locked_r;
    logic       lockedNxt_s;
    logic       lossEvent_s;

    logic [9:0] win_s;
    logic       match_s;
    logic       boundary_s;
    logic [3:0] commaInc_s;
    logic [3:0] lossInc_s;

    // Post-shift window, comma detection and saturating counter increments
    always_comb begin
        win_s      = {shiftReg_r, rxClocked};
        match_s    = (win_s == COMMA_P) || (win_s == COMMA_N);
        boundary_s = (bitCnt_r == 4'd9);
        commaInc_s = (commaCnt_r == 4'hF) ? commaCnt_r : commaCnt_r + 4'd1;
        lossInc_s  = (lossCnt_r == 4'hF) ? lossCnt_r : lossCnt_r + 4'd1;
    end

    // Alignment state machine and symbol emission, evaluated per bit strobe
    always_comb begin
        stateNxt_s       = state_r;
        bitCntNxt_s      = bitCnt_r;
        commaCntNxt_s    = commaCnt_r;
        lossCntNxt_s     = lossCnt_r;
        symbolNxt_s      = symbol_r;
        isCommaNxt_s     = isComma_r;
        symbolValidNxt_s = 1'b0;
        lockedNxt_s      = locked_r;
        lossEvent_s      = 1'b0;
        if (clkStrobe) begin
            bitCntNxt_s = boundary_s ? 4'd0 : bitCnt_r + 4'd1;
            case (state_r)
                HUNT: begin
                    if (match_s) begin
                        bitCntNxt_s   = 4'd0;
                        commaCntNxt_s = 4'd1;
                        if (LOCK_TH <= 4'd1) begin
                            stateNxt_s   = LOCKED;
                            lockedNxt_s  = 1'b1;
                            lossCntNxt_s = 4'd0;
                        end else begin
                            stateNxt_s = CHECK;
                        end
                    end else begin
                        stateNxt_s = HUNT;
                    end
                end
                CHECK: begin
                    if (boundary_s && match_s) begin
                        commaCntNxt_s = commaInc_s;
                        if (commaInc_s >= LOCK_TH) begin
                            stateNxt_s   = LOCKED;
                            lockedNxt_s  = 1'b1;
                            lossCntNxt_s = 4'd0;
                        end else begin
                            stateNxt_s = CHECK;
                        end
                    end else if (match_s) begin
                        // comma off the current grid: restart alignment from here
                        bitCntNxt_s   = 4'd0;
                        commaCntNxt_s = 4'd1;
                    end else begin
                        commaCntNxt_s = commaCnt_r;
                    end
                end
                LOCKED: begin
                    if (boundary_s) begin
                        symbolNxt_s      = win_s;
                        isCommaNxt_s     = match_s;
                        symbolValidNxt_s = 1'b1;
                        if (match_s) begin
                            lossCntNxt_s = 4'd0;
                        end else begin
                            lossCntNxt_s = lossCnt_r;
                        end
                    end else if (match_s) begin
                        lossCntNxt_s = lossInc_s;
                        if (lossInc_s >= LOSS_TH) begin
                            stateNxt_s  = HUNT;
                            lockedNxt_s = 1'b0;
                            lossEvent_s = 1'b1;
                        end else begin
                            stateNxt_s = LOCKED;
                        end
                    end else begin
                        lossCntNxt_s = lossCnt_r;
                    end
                end
                default: begin
                    stateNxt_s  = HUNT;
                    lockedNxt_s = 1'b0;
                end
            endcase
        end else begin
            bitCntNxt_s = bitCnt_r;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= HUNT;
            shiftReg_r    <= 9'd0;
            bitCnt_r      <= 4'd0;
            commaCnt_r    <= 4'd0;
            lossCnt_r     <= 4'd0;
            symbol_r      <= 10'd0;
            symbolValid_r <= 1'b0;
            isComma_r     <= 1'b0;
            locked_r      <= 1'b0;
        end else begin
            state_r       <= stateNxt_s;
            shiftReg_r    <= clkStrobe ? win_s[8:0] : shiftReg_r;
            bitCnt_r      <= bitCntNxt_s;
            commaCnt_r    <= commaCntNxt_s;
            lossCnt_r     <= lossCntNxt_s;
            symbol_r      <= symbolNxt_s;
            symbolValid_r <= symbolValidNxt_s;
            isComma_r     <= isCommaNxt_s;
            locked_r      <= lockedNxt_s;
        end
    end

    assign symbol      = symbol_r;
    assign symbolValid = symbolValid_r;
    assign isComma     = isComma_r;
    assign locked      = locked_r;

`ifdef COMMA_ALIGN_DESER_LOSS_CNT_EN
    logic [7:0] lossEvents_r;

    // Saturating count of LOCKED->HUNT transitions
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lossEvents_r <= 8'd0;
        end else if (lossEvent_s && (lossEvents_r != 8'hFF)) begin
            lossEvents_r <= lossEvents_r + 8'd1;
        end else begin
            lossEvents_r <= lossEvents_r;
        end
    end

    assign lossEvents = lossEvents_r;
`else
    logic unusedLoss_s;
    assign unusedLoss_s = lossEvent_s;
`endif

endmodule

// File: tb/tb_comma_align_deser.sv
// Directed bench for comma_align_deser: a bit-history model predicts every output each cycle,
// and literal expectations pin the key events (lock, loss, emitted symbols, async reset).
module tb_comma_align_deser;

    localparam logic [9:0] P  = 10'b0011111010;
    localparam logic [9:0] N  = 10'b1100000101;
    localparam logic [9:0] D0 = 10'b1001110100;
    localparam int LOCK_N = 3;
    localparam int LOSS_N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       clkStrobe;
    logic       rxClocked;
    logic [9:0] symbol;
    logic       symbolValid;
    logic       isComma;
    logic       locked;
`ifdef COMMA_ALIGN_DESER_LOSS_CNT_EN
    logic [7:0] lossEvents;
`endif

    comma_align_deser dut (
        .clk        (clk),
        .rst        (rst),
        .clkStrobe  (clkStrobe),
        .rxClocked  (rxClocked),
        .symbol     (symbol),
        .symbolValid(symbolValid),
        .isComma    (isComma),
        .locked     (locked)
`ifdef COMMA_ALIGN_DESER_LOSS_CNT_EN
        ,
        .lossEvents (lossEvents)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int gap    = 1;
    int vcnt   = 0;
    bit checkEn = 1'b0;

    // model: mode 0=hunting, 1=checking, 2=locked; alignment tracked as absolute bit index
    int         mMode;
    int         mBitIdx;
    int         mAlignIdx;
    int         mCc;
    int         mLc;
    int         mLossEv;
    logic [9:0] mWin;
    logic [9:0] expSym;
    logic       expValid;
    logic       expComma;
    logic       expLocked;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mMode = 0; mBitIdx = 0; mAlignIdx = 0; mCc = 0; mLc = 0; mLossEv = 0;
        mWin = 10'd0; expSym = 10'd0; expValid = 1'b0; expComma = 1'b0; expLocked = 1'b0;
    endtask

    task automatic modelStep(input logic s, input logic b);
        logic m;
        logic bnd;
        expValid = 1'b0;
        if (s) begin
            mBitIdx++;
            mWin = {mWin[8:0], b};
            m    = (mWin == P) || (mWin == N);
            bnd  = ((mBitIdx - mAlignIdx) % 10) == 0;
            if (mMode == 0) begin
                if (m) begin
                    mAlignIdx = mBitIdx; mCc = 1;
                    if (LOCK_N == 1) begin mMode = 2; expLocked = 1'b1; mLc = 0; end
                    else mMode = 1;
                end
            end else if (mMode == 1) begin
                if (m && bnd) begin
                    mCc++;
                    if (mCc >= LOCK_N) begin mMode = 2; expLocked = 1'b1; mLc = 0; end
                end else if (m) begin
                    mAlignIdx = mBitIdx; mCc = 1;
                end
            end else begin
                if (bnd) begin
                    expSym = mWin; expComma = m; expValid = 1'b1;
                    if (m) mLc = 0;
                end else if (m) begin
                    mLc++;
                    if (mLc >= LOSS_N) begin
                        mMode = 0; expLocked = 1'b0;
                        if (mLossEv < 255) mLossEv++;
                    end
                end
            end
        end
    endtask

    task automatic tick(input logic s, input logic b);
        clkStrobe = s;
        rxClocked = b;
        @(posedge clk);
        #1;
        modelStep(s, b);
        if (symbolValid) vcnt++;
        clkStrobe = 1'b0;
        rxClocked = 1'b0;
    endtask

    task automatic sendBit(input logic b);
        for (int i = 1; i < gap; i++) tick(1'b0, 1'b0);
        tick(1'b1, b);
    endtask

    task automatic sendSym(input logic [9:0] s);
        for (int i = 9; i >= 0; i--) sendBit(s[i]);
    endtask

    task automatic syncReset();
        rst = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (checkEn) begin
            chk("symbol", {22'd0, symbol}, {22'd0, expSym});
            chk("symbolValid", {31'd0, symbolValid}, {31'd0, expValid});
            chk("isComma", {31'd0, isComma}, {31'd0, expComma});
            chk("locked", {31'd0, locked}, {31'd0, expLocked});
`ifdef COMMA_ALIGN_DESER_LOSS_CNT_EN
            chk("lossEvents", {24'd0, lossEvents}, mLossEv);
`endif
        end
    end

    initial begin
        rst = 1'b0; clkStrobe = 1'b0; rxClocked = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_symbol", {22'd0, symbol}, 32'd0);
        chk("rst_valid", {31'd0, symbolValid}, 32'd0);
        chk("rst_isComma", {31'd0, isComma}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        rst = 1'b1;
        checkEn = 1'b1;

        // lock acquisition at bit offset 3, one strobe per 10 clks
        gap = 10;
        for (int i = 0; i < 3; i++) sendBit(1'b0);
        sendSym(N);
        sendSym(P);
        chk("lock_after2", {31'd0, locked}, 32'd0);
        sendSym(N);
        chk("lock_after3", {31'd0, locked}, 32'd1);
        sendSym(P);
        chk("sym1_valid", {31'd0, symbolValid}, 32'd1);
        chk("sym1", {22'd0, symbol}, {22'd0, P});
        chk("sym1_comma", {31'd0, isComma}, 32'd1);
        sendSym(N);
        chk("sym2", {22'd0, symbol}, {22'd0, N});
        chk("sym2_comma", {31'd0, isComma}, 32'd1);

        // data passthrough with back-to-back strobes
        gap = 1;
        vcnt = 0;
        for (int k = 0; k < 5; k++) begin
            sendSym(D0);
            chk("data_sym", {22'd0, symbol}, {22'd0, D0});
            chk("data_comma", {31'd0, isComma}, 32'd0);
        end
        chk("data_pulses", vcnt, 32'd5);

        // asynchronous reset mid-symbol
        for (int i = 9; i > 5; i--) sendBit(D0[i]);
        checkEn = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_locked", {31'd0, locked}, 32'd0);
        chk("arst_valid", {31'd0, symbolValid}, 32'd0);
        chk("arst_symbol", {22'd0, symbol}, 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        checkEn = 1'b1;
        vcnt = 0;
        sendSym(P);
        sendSym(N);
        chk("relock_after2", {31'd0, locked}, 32'd0);
        sendSym(P);
        chk("relock_after3", {31'd0, locked}, 32'd1);
        chk("no_valid_pre_lock", vcnt, 32'd0);
        sendSym(D0);
        chk("first_valid_post_lock", vcnt, 32'd1);
        chk("post_reset_sym", {22'd0, symbol}, {22'd0, D0});

        // slip: one bit lost, then misaligned commas until lock drops
        for (int i = 9; i > 0; i--) sendBit(D0[i]);
        sendSym(P);
        sendSym(N);
        sendSym(P);
        chk("slip_still_locked", {31'd0, locked}, 32'd1);
        sendSym(N);
        chk("slip_lost", {31'd0, locked}, 32'd0);
        sendSym(P);
        sendSym(N);
        chk("slip_relock_after2", {31'd0, locked}, 32'd0);
        sendSym(P);
        chk("slip_relock", {31'd0, locked}, 32'd1);
        sendSym(D0);
        chk("slip_data_valid", {31'd0, symbolValid}, 32'd1);
        chk("slip_data_sym", {22'd0, symbol}, {22'd0, D0});

        // realign while checking: comma at offset 0, then comma at offset 5
        syncReset();
        gap = 2;
        vcnt = 0;
        sendSym(N);
        for (int i = 0; i < 5; i++) sendBit(1'b0);
        sendSym(P);
        sendSym(N);
        chk("realign_not_locked", {31'd0, locked}, 32'd0);
        sendSym(P);
        chk("realign_locked", {31'd0, locked}, 32'd1);
        chk("realign_no_valid", vcnt, 32'd0);
        sendSym(D0);
        chk("realign_valid", vcnt, 32'd1);
        chk("realign_sym", {22'd0, symbol}, {22'd0, D0});

`ifdef COMMA_ALIGN_DESER_LOSS_CNT_EN
        // 300 forced lock losses
        gap = 1;
        for (int r = 0; r < 300; r++) begin
            sendBit(1'b0);
            for (int k = 0; k < 4; k++) sendSym(P);
            if (r == 0) chk("loss_first", {24'd0, lossEvents}, 32'd1);
            for (int k = 0; k < 3; k++) sendSym(P);
        end
        chk("loss_saturated", {24'd0, lossEvents}, 32'd255);
        chk("loss_relocked", {31'd0, locked}, 32'd1);
        syncReset();
        chk("loss_cleared", {24'd0, lossEvents}, 32'd0);
`endif

        repeat (3) tick(1'b0, 1'b0);
        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
